// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register with valid/ready flow control and a two-entry skid buffer.
// Latency: 1 cycle from an accepted input to valid_o; throughput is 1 entry per cycle while ready_i=1.
// Backpressure: ready_o is registered and falls one cycle after the stall that fills the skid entry.
module exmem_skid_stage #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The state encoding equals the number of held entries, so occ_o is a copy of the next state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              valid_q;
  logic              ready_q;
  logic [1:0]        occ_q;

  // Main entry (drives the outputs) and skid entry.
  logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
  logic [DATA_W-1:0] m_data_q, s_data_q;
  logic [ADDR_W-1:0] m_addr_q, s_addr_q;

  logic [CNT_W-1:0]  stall_q;

  logic in_fire;
  logic out_fire;
  logic load_m;
  logic load_s;
  logic shift_s;

  // State register; status outputs are registered copies decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      occ_q   <= state_d;
    end
  end

  // Next-state logic; flush wins over any handshake and empties the stage.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_d = FULL;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        FULL:  if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake decode, datapath enables and bubble-gated control output.
  always_comb begin
    in_fire  = valid_i & ready_q;
    out_fire = valid_q & ready_i;
    load_m   = 1'b0;
    load_s   = 1'b0;
    shift_s  = 1'b0;
    case (state_q)
      EMPTY: load_m  = in_fire;
      ONE: begin
        load_m = in_fire & out_fire;
        load_s = in_fire & ~out_fire;
      end
      FULL:  shift_s = out_fire;
      default: ;
    endcase
    ctrl_o = m_ctrl_q & {CTRL_W{valid_q}};
  end

  // Entry storage; flush only clears control so a bubble can never carry an enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_ctrl_q <= '0;
      m_data_q <= '0;
      m_addr_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      s_addr_q <= '0;
    end else if (flush_i) begin
      m_ctrl_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      if (load_m) begin
        m_ctrl_q <= ctrl_i;
        m_data_q <= data_i;
        m_addr_q <= addr_i;
      end else if (shift_s) begin
        m_ctrl_q <= s_ctrl_q;
        m_data_q <= s_data_q;
        m_addr_q <= s_addr_q;
      end
      if (load_s) begin
        s_ctrl_q <= ctrl_i;
        s_data_q <= data_i;
        s_addr_q <= addr_i;
      end
    end
  end

  // Saturating count of stalled output cycles; survives flush, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (valid_q && !ready_i && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign valid_o     = valid_q;
  assign ready_o     = ready_q;
  assign data_o      = m_data_q;
  assign addr_o      = m_addr_q;
  assign occ_o       = occ_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed bench for exmem_skid_stage: reset, streaming, skid, flush and counter saturation.
module tb_exmem_skid_stage;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              vin;
  logic              rdy_o;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr_in;
  logic              vout;
  logic              rdy_in;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr_out;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall;

  int checks = 0;
  int errors = 0;

  exmem_skid_stage #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .valid_i(vin), .ready_o(rdy_o),
    .ctrl_i(ctrl_in), .data_i(data_in), .addr_i(addr_in),
    .valid_o(vout), .ready_i(rdy_in),
    .ctrl_o(ctrl_out), .data_o(data_out), .addr_o(addr_out),
    .occ_o(occ), .stall_cnt_o(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are examined 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy_in = 1'b1;
    ctrl_in = '0; data_in = '0; addr_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; vin = 1'b1; rdy_in = 1'b1;
    ctrl_in = 4'hF; data_in = 128'd5; addr_in = 5'd7;
    tick();
    tick();
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", vout); end
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", rdy_o); end
    checks++; if (ctrl_out !== 4'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl_out); end
    checks++; if (data_out !== 128'd0) begin errors++; $display("FAIL reset_data got %0d want 0", data_out); end
    checks++; if (addr_out !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr_out); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ); end
    checks++; if (stall !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall); end
    rst = 1'b0; vin = 1'b0;
    tick();
    checks++; if (ctrl_out !== 4'h0) begin errors++; $display("FAIL bubble_ctrl got %h want 0", ctrl_out); end
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b want 0", vout); end
  endtask

  task automatic test_stream();
    do_reset();
    rdy_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vin = 1'b1; data_in = DATA_W'(i); addr_in = ADDR_W'(i); ctrl_in = 4'h9;
      tick();
      checks++; if (vout !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, vout); end
      checks++; if (data_out !== DATA_W'(i)) begin errors++; $display("FAIL stream_data[%0d] got %0d want %0d", i, data_out, i); end
      checks++; if (addr_out !== ADDR_W'(i)) begin errors++; $display("FAIL stream_addr[%0d] got %0d want %0d", i, addr_out, i); end
      checks++; if (ctrl_out !== 4'h9) begin errors++; $display("FAIL stream_ctrl[%0d] got %h want 9", i, ctrl_out); end
      checks++; if (occ !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occ); end
      checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, rdy_o); end
    end
    vin = 1'b0;
    tick();
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b want 0", vout); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL stream_drain_occ got %0d want 0", occ); end
    checks++; if (stall !== 4'd0) begin errors++; $display("FAIL stream_stall got %0d want 0", stall); end
  endtask

  task automatic test_skid();
    // Per step: inputs (valid_i, data_i, ready_i) then expected state after the edge.
    logic       s_vin [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int         s_din [8] = '{1, 2, 3, 3, 3, 3, 4, 4};
    logic       s_rdy [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
    logic       e_vo  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int         e_do  [8] = '{1, 1, 1, 1, 2, 3, 4, 0};
    logic [1:0] e_occ [8] = '{1, 2, 2, 2, 1, 1, 1, 0};
    logic       e_ro  [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
    logic [3:0] e_st  [8] = '{0, 1, 2, 3, 3, 3, 3, 3};
    do_reset();
    ctrl_in = 4'h3;
    for (int k = 0; k < 8; k++) begin
      vin = s_vin[k]; data_in = DATA_W'(s_din[k]); addr_in = ADDR_W'(s_din[k]); rdy_in = s_rdy[k];
      tick();
      checks++; if (vout !== e_vo[k]) begin errors++; $display("FAIL skid_valid[%0d] got %b want %b", k, vout, e_vo[k]); end
      if (e_vo[k]) begin
        checks++; if (data_out !== DATA_W'(e_do[k])) begin errors++; $display("FAIL skid_data[%0d] got %0d want %0d", k, data_out, e_do[k]); end
      end
      checks++; if (occ !== e_occ[k]) begin errors++; $display("FAIL skid_occ[%0d] got %0d want %0d", k, occ, e_occ[k]); end
      checks++; if (rdy_o !== e_ro[k]) begin errors++; $display("FAIL skid_ready[%0d] got %b want %b", k, rdy_o, e_ro[k]); end
      checks++; if (stall !== e_st[k]) begin errors++; $display("FAIL skid_stall[%0d] got %0d want %0d", k, stall, e_st[k]); end
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    ctrl_in = 4'hF; rdy_in = 1'b0;
    vin = 1'b1; data_in = 128'd10; tick();
    vin = 1'b1; data_in = 128'd11; tick();
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL ffull_pre_occ got %0d want 2", occ); end
    flush = 1'b1; vin = 1'b1; data_in = 128'd12;
    tick();
    flush = 1'b0;
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL ffull_valid got %b want 0", vout); end
    checks++; if (ctrl_out !== 4'h0) begin errors++; $display("FAIL ffull_ctrl got %h want 0", ctrl_out); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL ffull_occ got %0d want 0", occ); end
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL ffull_ready got %b want 1", rdy_o); end
    checks++; if (stall !== 4'd2) begin errors++; $display("FAIL ffull_stall got %0d want 2", stall); end
    vin = 1'b0; rdy_in = 1'b1;
    tick();
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL ffull_idle_valid got %b want 0", vout); end
    vin = 1'b1; data_in = 128'd13; ctrl_in = 4'h5;
    tick();
    vin = 1'b0;
    checks++; if (data_out !== 128'd13) begin errors++; $display("FAIL ffull_next_data got %0d want 13", data_out); end
    checks++; if (ctrl_out !== 4'h5) begin errors++; $display("FAIL ffull_next_ctrl got %h want 5", ctrl_out); end
  endtask

  task automatic test_flush_out();
    do_reset();
    rdy_in = 1'b1; ctrl_in = 4'h1;
    vin = 1'b1; data_in = 128'd20; tick();
    vin = 1'b0;
    checks++; if (vout !== 1'b1 || data_out !== 128'd20) begin errors++; $display("FAIL fout_present got v=%b d=%0d want v=1 d=20", vout, data_out); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL fout_valid got %b want 0", vout); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL fout_occ got %0d want 0", occ); end
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL fout_ready got %b want 1", rdy_o); end
    tick();
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL fout_no_redeliver got %b want 0", vout); end
  endtask

  task automatic test_saturation();
    do_reset();
    rdy_in = 1'b0; ctrl_in = 4'h2;
    vin = 1'b1; data_in = 128'd30; tick();
    vin = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 14) begin
        checks++; if (stall !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", stall); end
      end
      if (c == 15) begin
        checks++; if (stall !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d want 15", stall); end
      end
    end
    checks++; if (stall !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stall); end
    checks++; if (vout !== 1'b1 || data_out !== 128'd30) begin errors++; $display("FAIL sat_stable got v=%b d=%0d want v=1 d=30", vout, data_out); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (stall !== 4'd15) begin errors++; $display("FAIL sat_after_flush got %0d want 15", stall); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (stall !== 4'd0) begin errors++; $display("FAIL sat_after_reset got %0d want 0", stall); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy_in = 1'b1;
    ctrl_in = '0; data_in = '0; addr_in = '0;
    test_reset();
    test_stream();
    test_skid();
    test_flush_full();
    test_flush_out();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
